// File: rtl/push_button_bounce_gen.sv
// Emulated active-low push button: bounce burst on press, clean hold, bounce
// burst on release, settle interval, plus a two-digit BCD tally of completed presses.
module push_button_bounce_gen #(
  parameter int          TICK_DIV     = 49999,
  parameter int          BOUNCE_PAIRS = 3,
  parameter int          SETTLE_TICKS = 20,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       CLOCK_50_I,
  input  logic       RESET_I,
  input  logic       START_I,
  input  logic [7:0] HOLD_MS_I,
  output logic       PUSH_BUTTON_N_O,
  output logic       BUSY_O,
  output logic       DONE_O,
  output logic [7:0] PRESS_COUNT_O
);

  localparam int                DIV_W      = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_MAX    = DIV_W'(TICK_DIV);
  localparam logic [3:0]        LAST_EDGE  = 4'(2 * BOUNCE_PAIRS - 1);
  localparam logic [7:0]        SETTLE_LEN = 8'(SETTLE_TICKS);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    RELEASE_BOUNCE,
    SETTLE
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [7:0]       tick_left, tick_nxt;
  logic [3:0]       edge_cnt, edge_nxt;
  logic [7:0]       hold_len, hold_nxt;
  logic [15:0]      lfsr, lfsr_nxt;
  logic             line, line_nxt;
  logic             busy, busy_nxt;
  logic             done, done_nxt;
  logic [7:0]       count, count_nxt;
  logic             tick;
  logic             seg_end;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] seg_len(input logic [15:0] v);
    return {6'd0, v[1:0]} + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  // Every duration is a down-count of ticks; the divider restarts on each edge
  // and state change so durations are exact multiples of TICK_DIV+1 clocks.
  assign tick    = (div_cnt == DIV_MAX);
  assign seg_end = tick && (tick_left == 8'd1);

  always_comb begin
    state_nxt = state;
    div_nxt   = tick ? '0 : div_cnt + DIV_W'(1);
    tick_nxt  = tick ? tick_left - 8'd1 : tick_left;
    edge_nxt  = edge_cnt;
    hold_nxt  = hold_len;
    lfsr_nxt  = lfsr;
    line_nxt  = line;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    count_nxt = count;
    case (state)
      IDLE: begin
        div_nxt  = '0;
        tick_nxt = tick_left;
        line_nxt = 1'b1;
        busy_nxt = 1'b0;
        if (START_I) begin
          hold_nxt = (HOLD_MS_I == 8'd0) ? 8'd1 : HOLD_MS_I;
          line_nxt = 1'b0;
          busy_nxt = 1'b1;
          edge_nxt = 4'd1;
          if (LAST_EDGE == 4'd1) begin
            state_nxt = HOLD;
            tick_nxt  = hold_nxt;
          end else begin
            state_nxt = PRESS_BOUNCE;
            tick_nxt  = seg_len(lfsr);
            lfsr_nxt  = lfsr_step(lfsr);
          end
        end
      end
      PRESS_BOUNCE, RELEASE_BOUNCE: begin
        if (seg_end) begin
          div_nxt  = '0;
          line_nxt = ~line;
          edge_nxt = edge_cnt + 4'd1;
          if (edge_cnt + 4'd1 == LAST_EDGE) begin
            if (state == PRESS_BOUNCE) begin
              state_nxt = HOLD;
              tick_nxt  = hold_len;
            end else begin
              state_nxt = SETTLE;
              tick_nxt  = SETTLE_LEN;
            end
          end else begin
            tick_nxt = seg_len(lfsr);
            lfsr_nxt = lfsr_step(lfsr);
          end
        end
      end
      HOLD: begin
        if (seg_end) begin
          div_nxt  = '0;
          line_nxt = 1'b1;
          edge_nxt = 4'd1;
          if (LAST_EDGE == 4'd1) begin
            state_nxt = SETTLE;
            tick_nxt  = SETTLE_LEN;
          end else begin
            state_nxt = RELEASE_BOUNCE;
            tick_nxt  = seg_len(lfsr);
            lfsr_nxt  = lfsr_step(lfsr);
          end
        end
      end
      SETTLE: begin
        if (seg_end) begin
          div_nxt   = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          count_nxt = bcd_inc(count);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tick_left <= 8'd0;
      edge_cnt  <= 4'd0;
      hold_len  <= 8'd0;
      lfsr      <= LFSR_SEED;
      line      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= 8'h00;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      tick_left <= tick_nxt;
      edge_cnt  <= edge_nxt;
      hold_len  <= hold_nxt;
      lfsr      <= lfsr_nxt;
      line      <= line_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      count     <= count_nxt;
    end
  end

  assign PUSH_BUTTON_N_O = line;
  assign BUSY_O          = busy;
  assign DONE_O          = done;
  assign PRESS_COUNT_O   = count;

endmodule
